// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
package ps2_pkg;

  // Scan code bytes recognised by the decoder
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronizers, ps2_clk glitch
// filter, bit shifter, parity/stop check and mid-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(FRAME_BITS);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FILT_ONE  = FW'(1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_DLAST = BW'(8);
  localparam logic [BW-1:0] BIT_PAR   = BW'(9);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          fall;
  logic          din;

  // Synchronizers and glitch filter: a level change is accepted only after
  // FILTER_LEN consecutive samples disagree with the current filtered level.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and infers a latch.
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    filt_d     = filt_q;
    fcnt_d     = '0;
    fall       = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = clk_sync_q[1];
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + FILT_ONE;
      end
    end
  end

  assign din = dat_sync_q[1];

  // Frame shifter, parity/stop check and saturating mid-frame timeout.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == '0) begin
        // A high start bit is rejected; stay waiting for a real start.
        if (din) err_d = 1'b1;
        else     bit_cnt_d = BIT_ONE;
      end else if (bit_cnt_q <= BIT_DLAST) begin
        shift_d   = {din, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + BIT_ONE;
      end else if (bit_cnt_q == BIT_PAR) begin
        par_d     = din;
        bit_cnt_d = bit_cnt_q + BIT_ONE;
      end else begin
        bit_cnt_d = '0;
        if (din && (^{shift_q, par_q})) begin
          code_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_ONE;
      if ((to_cnt_q == TO_LAST) && (bit_cnt_q != '0)) begin
        err_d     = 1'b1;
        bit_cnt_d = '0;
      end
    end
  end

  // State registers; idle PS/2 lines are high, so sync stages and the
  // filter reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of every other flop.
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign scan_code  = code_q;
  assign scan_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_drive_keys.sv
// Keyboard front end for the car controls: PS/2 frame receiver plus an
// arrow make/break decoder holding left/right key levels.
// Build option: define PS2_WASD_ALIAS_EN to also decode non-extended
// 'A' (1C) and 'D' (23) onto left/right.
module ps2_drive_keys
  import ps2_pkg::*;
#(
  parameter int         FILTER_LEN  = 8,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] CODE_LEFT   = SC_LEFT,
  parameter logic [7:0] CODE_RIGHT  = SC_RIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left,
  output logic       right,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  dec_state_e state_q, state_d;
  logic       left_q, left_d;
  logic       right_q, right_d;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  // Make/break decoder; advances only on a good byte, so frame errors leave
  // the current prefix state intact.
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    right_d = right_q;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          if (scan_code == SC_EXT)      state_d = ST_EXT;
          else if (scan_code == SC_BRK) state_d = ST_BRK;
`ifdef PS2_WASD_ALIAS_EN
          else if (scan_code == SC_A)   left_d  = 1'b1;
          else if (scan_code == SC_D)   right_d = 1'b1;
`endif
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (scan_code == SC_BRK)          state_d = ST_EXT_BRK;
          else if (scan_code == CODE_LEFT)  left_d  = 1'b1;
          else if (scan_code == CODE_RIGHT) right_d = 1'b1;
          else if (scan_code == SC_EXT)     state_d = ST_EXT;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (scan_code == CODE_LEFT)       left_d  = 1'b0;
          else if (scan_code == CODE_RIGHT) right_d = 1'b0;
        end
        ST_BRK: begin
          state_d = ST_IDLE;
`ifdef PS2_WASD_ALIAS_EN
          if (scan_code == SC_A)      left_d  = 1'b0;
          else if (scan_code == SC_D) right_d = 1'b0;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Decoder state and key level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left  = left_q;
  assign right = right_q;

endmodule

// File: tb/tb_ps2_drive_keys.sv
// Self-checking bench for ps2_drive_keys: scoreboard of expected bytes plus
// per-scenario key-state and frame-error checks.
module tb_ps2_drive_keys;

  localparam int TO_CYC = 200;
  localparam int HALF   = 20;   // ps2_clk half period in clk cycles
  localparam int SETUP  = 10;   // data setup before the falling edge
`ifdef PS2_WASD_ALIAS_EN
  localparam logic ALIAS = 1'b1;
`else
  localparam logic ALIAS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       left, right, scan_valid, frame_err;
  logic [7:0] scan_code;

  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  ps2_drive_keys #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .left      (left),
    .right     (right),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  // Scoreboard monitor: every scan_valid pulse must match the oldest byte sent.
  always @(negedge clk) begin
    if (reset === 1'b1 && scan_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scan_unexpected: got scan_code=%02h, expected no byte", scan_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (scan_code !== mon_exp) begin
          errors++;
          $display("FAIL scan_code: got %02h, expected %02h", scan_code, mon_exp);
        end
      end
    end
    if (reset === 1'b1 && frame_err === 1'b1) err_pulses++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of a frame; optional bad parity and 1-cycle glitches.
  task automatic send_bits(input logic [7:0] b, input int nbits,
                           input bit bad_par, input bit glitch);
    logic [10:0] f;
    logic        par;
    par = bad_par ? (^b) : ~(^b);
    f   = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch) begin
        idle(4);
        ps2_clk = 1'b0;
        idle(1);
        ps2_clk = 1'b1;
        idle(SETUP - 5);
      end else begin
        idle(SETUP);
      end
      ps2_clk = 1'b0;
      if (glitch) begin
        idle(6);
        ps2_clk = 1'b1;
        idle(1);
        ps2_clk = 1'b0;
        idle(HALF - 7);
      end else begin
        idle(HALF);
      end
      ps2_clk = 1'b1;
      idle(HALF - SETUP);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    exp_q.push_back(b);
    send_bits(b, 11, 1'b0, 1'b0);
    idle(20);
  endtask

  task automatic test_reset;
    idle(3);
    checks++;
    if ({left, right, scan_code, scan_valid, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_initial: got %03h, expected 000",
               {left, right, scan_code, scan_valid, frame_err});
    end
    reset = 1'b1;
    idle(5);
    send_bits(8'h55, 5, 1'b0, 1'b0);
    reset = 1'b0;
    idle(3);
    checks++;
    if ({left, right, scan_code, scan_valid, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_midframe: got %03h, expected 000",
               {left, right, scan_code, scan_valid, frame_err});
    end
    reset = 1'b1;
    idle(5);
    send_frame(8'h1C);
    checks++;
    if (scan_code !== 8'h1C) begin
      errors++;
      $display("FAIL reset_next_frame: got %02h, expected 1c", scan_code);
    end
    checks++;
    if (err_pulses !== 0) begin
      errors++;
      $display("FAIL reset_no_err: got %0d, expected 0", err_pulses);
    end
  endtask

  task automatic test_wasd;
    send_frame(8'h1C);
    checks++;
    if (left !== ALIAS || right !== 1'b0) begin
      errors++;
      $display("FAIL wasd_make: got left=%b right=%b, expected left=%b right=0", left, right, ALIAS);
    end
    send_frame(8'hF0);
    send_frame(8'h1C);
    checks++;
    if (left !== 1'b0) begin
      errors++;
      $display("FAIL wasd_break: got left=%b, expected 0", left);
    end
  endtask

  task automatic check_latency(input logic exp_l, input logic exp_r);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (scan_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL latency_wait: got no scan_valid, expected one within 2000 cycles");
    end else begin
      if (left !== 1'b0) begin
        errors++;
        $display("FAIL latency_early: got left=%b, expected 0 during scan_valid", left);
      end
      @(negedge clk);
      checks++;
      if (left !== exp_l || right !== exp_r) begin
        errors++;
        $display("FAIL latency_after: got left=%b right=%b, expected left=%b right=%b",
                 left, right, exp_l, exp_r);
      end
    end
  endtask

  task automatic test_arrows;
    send_frame(8'hE0);
    fork
      send_frame(8'h6B);
      check_latency(1'b1, 1'b0);
    join
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h6B);
    checks++;
    if (left !== 1'b0 || right !== 1'b0) begin
      errors++;
      $display("FAIL arrow_release: got left=%b right=%b, expected 0 0", left, right);
    end
  endtask

  task automatic test_both;
    send_frame(8'hE0);
    send_frame(8'h74);
    checks++;
    if ({left, right} !== 2'b01) begin
      errors++;
      $display("FAIL both_right: got %b, expected 01", {left, right});
    end
    send_frame(8'hE0);
    send_frame(8'h6B);
    checks++;
    if ({left, right} !== 2'b11) begin
      errors++;
      $display("FAIL both_held: got %b, expected 11", {left, right});
    end
    // Typematic repeat of the held left arrow keeps both bits set
    send_frame(8'hE0);
    send_frame(8'h6B);
    checks++;
    if ({left, right} !== 2'b11) begin
      errors++;
      $display("FAIL both_repeat: got %b, expected 11", {left, right});
    end
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h74);
    checks++;
    if ({left, right} !== 2'b10) begin
      errors++;
      $display("FAIL both_release_right: got %b, expected 10", {left, right});
    end
  endtask

  task automatic test_parity;
    int e0;
    e0 = err_pulses;
    send_bits(8'h6B, 11, 1'b1, 1'b0);
    idle(20);
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL parity_err: got %0d pulses, expected %0d", err_pulses - e0, 1);
    end
    checks++;
    if (scan_code !== 8'h74 || left !== 1'b1) begin
      errors++;
      $display("FAIL parity_hold: got code=%02h left=%b, expected code=74 left=1", scan_code, left);
    end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_pulses;
    send_bits(8'hAA, 6, 1'b0, 1'b0);
    idle(100);
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL timeout_early: got %0d pulses, expected 0", err_pulses - e0);
    end
    idle(200);
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL timeout_err: got %0d pulses, expected 1", err_pulses - e0);
    end
    send_frame(8'hE0);
    checks++;
    if (scan_code !== 8'hE0 || err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL timeout_recover: got code=%02h pulses=%0d, expected code=e0 pulses=1",
               scan_code, err_pulses - e0);
    end
    send_frame(8'h00);
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_pulses;
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 11, 1'b0, 1'b1);
    idle(20);
    checks++;
    if (scan_code !== 8'h5A || err_pulses !== e0) begin
      errors++;
      $display("FAIL glitch_frame: got code=%02h pulses=%0d, expected code=5a pulses=0",
               scan_code, err_pulses - e0);
    end
  endtask

  initial begin
    test_reset();
    test_wasd();
    test_arrows();
    test_both();
    test_parity();
    test_timeout();
    test_glitch();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d bytes outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_drive_keys.md
Name: ps2_drive_keys

Overview:
- Keyboard front end for the car controls: receives PS/2 device-to-host frames and decodes arrow make/break sequences.
- Outputs level-held `left`/`right` key states that drive the player position logic directly.
- Sits between the board PS/2 pins and the player block, in the `clk` domain.

Parameters:
- FILTER_LEN, 8: consecutive equal samples required before a filtered ps2_clk level change is accepted.
- TIMEOUT_CYC, 50000: idle `clk` cycles mid-frame before the frame is abandoned (1 ms at 50 MHz).
- CODE_LEFT, 8'h6B: extended scan code for the left arrow.
- CODE_RIGHT, 8'h74: extended scan code for the right arrow.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- left  out  1  1 while the left arrow is held
- right  out  1  1 while the right arrow is held
- scan_code  out  8  last received byte
- scan_valid  out  1  one-cycle pulse when scan_code updates
- frame_err  out  1  one-cycle pulse on a bad start, parity, stop or timeout

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0) forces: left=0, right=0, scan_code=0, scan_valid=0, frame_err=0, decoder in IDLE, bit counter 0, filters at 1. Reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass a 2-FF synchronizer.
  - ps2_clk then goes through a FILTER_LEN-sample glitch filter.
  - A falling edge of the filtered clock samples the synchronized data.
- Frame: 11 bits = start(0), 8 data bits LSB first, odd parity, stop(1).
  - Start bit sampled as 1: frame_err pulses and the receiver waits for the next falling edge.
  - Timeout counter clears on every falling edge. Reaching TIMEOUT_CYC with bit count ≠ 0 pulses frame_err and clears the bit count. The counter saturates; no wrap.
  - On the stop-bit edge, frame OK: scan_code <= byte and scan_valid=1 in the next cycle.
  - On the stop-bit edge, bad parity or stop bit: frame_err=1 instead, and scan_code is unchanged.
- Decoder FSM, advanced only on scan_valid:
  - IDLE: E0→EXT; F0→BRK; else IDLE.
  - EXT: F0→EXT_BRK; CODE_LEFT→left=1, IDLE; CODE_RIGHT→right=1, IDLE; E0→EXT; else IDLE.
  - EXT_BRK: CODE_LEFT→left=0; CODE_RIGHT→right=0; any byte→IDLE.
  - BRK: any byte→IDLE (non-extended break ignored).
- Latency: left/right change in the cycle after the scan_valid pulse.
- Key states are independent. Both arrows held gives left=right=1; the player treats this as no movement.
- Typematic repeats of a held key re-set an already-set bit with no glitch.
- frame_err does not change FSM state. The next good byte is decoded from the current state.

Optional Feature:
- Macro: PS2_WASD_ALIAS_EN.
- Defined: states IDLE and BRK also decode non-extended 1C ('A') and 23 ('D').
  - IDLE: 1C sets left, 23 sets right.
  - BRK: 1C clears left, 23 clears right.
  - Arrows and letters share the same output bits; the last event wins.
- Undefined: non-extended codes never affect left/right, exactly as specified above.

Decomposition:
- Package ps2_pkg holds:
  - scan code constants: E0, F0, 6B, 74, 1C, 23;
  - decoder state typedef: IDLE, EXT, BRK, EXT_BRK;
  - frame length constant 11.
- Sub-module ps2_rx_frame contains the synchronizers, filter, bit shifter, parity/stop check and timeout, and outputs scan_code/scan_valid/frame_err.
- The top level adds the decoder FSM and the key registers.

Test Plan:
- Reset held low mid-frame, then released → all outputs 0; next full frame 0x1C gives scan_valid with scan_code=0x1C.
- Frames E0, 6B → left=1 one cycle after the second scan_valid, right=0; then E0, F0, 6B → left=0.
- E0,74 then E0,6B then E0,F0,74 → right=1, both=1, then left=1/right=0.
- Frame 0x6B with even parity → frame_err pulse, scan_valid stays 0, scan_code unchanged, left unchanged.
- Stop after 5 data bits, idle TIMEOUT_CYC (bench sets 200) cycles → frame_err pulse; following frame 0xE0 received cleanly.
- 1-cycle glitches on ps2_clk (shorter than FILTER_LEN) during a frame → no extra bits, byte decoded correctly.
- PS2_WASD_ALIAS_EN defined: 1C → left=1; F0,1C → left=0. Undefined: same stimulus → left stays 0.
